stream_fill: RTL and testbench

STREAM_FILL -- requirements
Module: stream_fill

---
 rtl/stream_fill_if.sv | 29 ++
 rtl/stream_fill.sv | 114 +++++++++++
 tb/tb_stream_fill.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/stream_fill_if.sv
// Bundles the stream input, the buffer write port and the token channel of stream_fill.
// The master modport is the fill block; the slave modport is its environment.
interface stream_fill_if #(
  parameter int W_A = 7,
  parameter int W_D = 32
);
  logic [W_D-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic [W_A-1:0] mem_addr;
  logic [W_D-1:0] mem_d;
  logic           mem_we;
  logic [W_D-1:0] comm_d;
  logic           comm_enq;
  logic           comm_full;
  logic [W_D-1:0] comm_q;
  logic           comm_deq;
  logic           comm_empty;

  modport master (
    input  in_data, in_valid, comm_full, comm_q, comm_empty,
    output in_ready, mem_addr, mem_d, mem_we, comm_d, comm_enq, comm_deq
  );

  modport slave (
    output in_data, in_valid, comm_full, comm_q, comm_empty,
    input  in_ready, mem_addr, mem_d, mem_we, comm_d, comm_enq, comm_deq
  );
endinterface

// File: rtl/stream_fill.sv
// Fills a SIZE-word buffer from a valid/ready stream, then posts the buffer checksum as a
// token and waits for an ack token (zero stops, non-zero starts the next buffer).
module stream_fill #(
  parameter int W_A  = 7,
  parameter int W_D  = 32,
  parameter int SIZE = 128
) (
  input  logic          CLK,
  input  logic          RST,
  stream_fill_if.master bus,
  output logic [15:0]   buf_count
);

  typedef enum logic [1:0] {IDLE, FILL, NOTIFY, WAIT_ACK} state_t;

  localparam logic [W_A-1:0] LAST = W_A'(SIZE - 1);

  state_t         state_reg, state_next;
  logic [W_A-1:0] count_reg;
  logic [W_D-1:0] sum_reg;
  logic [W_A-1:0] mem_addr_reg;
  logic [W_D-1:0] mem_d_reg;
  logic           mem_we_reg;
  logic [W_D-1:0] comm_d_reg;
  logic           comm_enq_reg;
  logic [15:0]    buf_count_reg;
  logic           deq_block_reg;

  logic           accept;
  logic           deq_next;
  logic           enq_next;
  logic           clear_next;

  // Dequeue is suppressed right after a dequeue and in the first cycle after reset,
  // so a token already waiting at reset release is not consumed in that cycle.
  always_comb begin
    state_next = state_reg;
    deq_next   = 1'b0;
    enq_next   = 1'b0;
    clear_next = 1'b0;
    accept     = bus.in_valid && (state_reg == FILL);
    case (state_reg)
      IDLE: begin
        if (!bus.comm_empty && !deq_block_reg) begin
          deq_next   = 1'b1;
          clear_next = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        if (accept && count_reg == LAST) begin
          state_next = NOTIFY;
        end
      end
      NOTIFY: begin
        if (!bus.comm_full) begin
          enq_next   = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!bus.comm_empty && !deq_block_reg) begin
          deq_next   = 1'b1;
          clear_next = 1'b1;
          state_next = (bus.comm_q == '0) ? IDLE : FILL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      sum_reg       <= '0;
      mem_addr_reg  <= '0;
      mem_d_reg     <= '0;
      mem_we_reg    <= 1'b0;
      comm_d_reg    <= '0;
      comm_enq_reg  <= 1'b0;
      buf_count_reg <= '0;
      deq_block_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      deq_block_reg <= deq_next;
      mem_we_reg    <= accept;
      comm_enq_reg  <= enq_next;
      if (accept) begin
        mem_addr_reg <= count_reg;
        mem_d_reg    <= bus.in_data;
        count_reg    <= count_reg + W_A'(1);
        sum_reg      <= sum_reg + bus.in_data;
      end else if (clear_next) begin
        count_reg <= '0;
        sum_reg   <= '0;
      end
      if (enq_next) begin
        comm_d_reg    <= sum_reg;
        buf_count_reg <= buf_count_reg + 16'd1;
      end
    end
  end

  assign bus.in_ready = (state_reg == FILL);
  assign bus.mem_addr = mem_addr_reg;
  assign bus.mem_d    = mem_d_reg;
  assign bus.mem_we   = mem_we_reg;
  assign bus.comm_d   = comm_d_reg;
  assign bus.comm_enq = comm_enq_reg;
  assign bus.comm_deq = deq_next;
  assign buf_count    = buf_count_reg;

endmodule

// File: tb/tb_stream_fill.sv
// Self-checking bench for stream_fill: a table of buffer fills plus a mid-fill reset,
// with expected writes and tokens queued as stimulus is driven and popped on output.
module tb_stream_fill;
  localparam int W_A  = 7;
  localparam int W_D  = 32;
  localparam int SIZE = 128;

  typedef struct {
    int          mode;        // 0: words 1..SIZE, 1: all ones, 2: constant 2
    bit          toggle;      // in_valid low every other cycle
    int          full_cycles; // comm_full held this long at NOTIFY
    bit          extra;       // keep offering a word after the buffer is full
    logic [31:0] ack;
    logic [31:0] exp_sum;
    logic [15:0] exp_bc;
  } row_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] buf_count;

  stream_fill_if #(.W_A(W_A), .W_D(W_D)) bus ();

  stream_fill #(.W_A(W_A), .W_D(W_D), .SIZE(SIZE)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus.master),
    .buf_count (buf_count)
  );

  always #5 CLK = ~CLK;

  int          n_vec = 0;
  int          n_err = 0;
  logic [38:0] wq[$];
  logic [47:0] tq[$];
  bit          model_ready = 1'b0;
  int          word_idx = 0;
  bit          exp_we = 1'b0;
  bit          prev_deq = 1'b0;
  logic [31:0] last_tok = '0;
  row_t        rows[3];
  row_t        rst_row;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] data_for(input int mode, input int i);
    case (mode)
      0:       return 32'(i + 1);
      1:       return 32'hFFFF_FFFF;
      default: return 32'd2;
    endcase
  endfunction

  // One clock: check outputs at the falling edge, record expected effects of this
  // cycle's inputs, return just after the next rising edge.
  task automatic cycle(output bit deq_seen);
    logic [38:0] w;
    logic [47:0] t;
    @(negedge CLK);
    chk("in_ready", bus.in_ready, model_ready);
    chk("mem_we", bus.mem_we, exp_we);
    if (bus.mem_we && wq.size() > 0) begin
      w = wq.pop_front();
      chk("mem_addr", bus.mem_addr, w[38:32]);
      chk("mem_d", bus.mem_d, w[31:0]);
    end
    if (bus.comm_enq) begin
      if (tq.size() == 0) begin
        chk("comm_enq", bus.comm_enq, 0);
      end else begin
        t = tq.pop_front();
        chk("comm_d", bus.comm_d, t[31:0]);
        chk("buf_count", buf_count, t[47:32]);
        last_tok = t[31:0];
      end
    end else begin
      chk("comm_d_hold", bus.comm_d, last_tok);
    end
    chk("deq_consecutive", bus.comm_deq & prev_deq, 0);
    deq_seen = bus.comm_deq;
    prev_deq = bus.comm_deq;
    exp_we   = bus.in_valid && model_ready;
    if (exp_we) begin
      wq.push_back({word_idx[6:0], bus.in_data});
      word_idx++;
      if (word_idx == SIZE) model_ready = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic send_token(input logic [31:0] val);
    bit d;
    bit got;
    got = 1'b0;
    bus.comm_q     = val;
    bus.comm_empty = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      cycle(d);
      if (d) got = 1'b1;
    end
    bus.comm_empty = 1'b1;
    chk("deq_timeout", got, 1);
  endtask

  task automatic check_zero();
    @(negedge CLK);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_d", bus.mem_d, 0);
    chk("rst_comm_d", bus.comm_d, 0);
    chk("rst_comm_enq", bus.comm_enq, 0);
    chk("rst_comm_deq", bus.comm_deq, 0);
    chk("rst_buf_count", buf_count, 0);
    prev_deq = bus.comm_deq;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_row(input row_t r);
    bit d;
    bus.comm_full = (r.full_cycles > 0);
    for (int i = 0; i < SIZE; i++) begin
      if (r.toggle) begin
        bus.in_valid = 1'b0;
        cycle(d);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = data_for(r.mode, i);
      cycle(d);
    end
    bus.in_data  = 32'h0BAD_0BAD;
    bus.in_valid = r.extra;
    for (int i = 0; i < r.full_cycles; i++) cycle(d);
    tq.push_back({r.exp_bc, r.exp_sum});
    bus.comm_full = 1'b0;
    cycle(d);
    cycle(d);
    chk("enq_missing", tq.size(), 0);
    cycle(d);
    bus.in_valid = 1'b0;
    send_token(r.ack);
    if (r.ack != 0) begin
      model_ready = 1'b1;
      word_idx    = 0;
    end else begin
      repeat (3) cycle(d);
    end
  endtask

  initial begin
    bit d;
    rows[0] = '{0, 1'b0, 0,  1'b1, 32'd5, 32'd8256,      16'd1};
    rows[1] = '{1, 1'b0, 10, 1'b0, 32'd9, 32'hFFFF_FF80, 16'd2};
    rows[2] = '{0, 1'b1, 0,  1'b0, 32'd0, 32'd8256,      16'd3};
    rst_row = '{2, 1'b0, 0,  1'b0, 32'd0, 32'd256,       16'd1};

    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    bus.comm_full  = 1'b0;
    bus.comm_q     = '0;
    bus.comm_empty = 1'b1;

    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check_zero();
    repeat (2) cycle(d);

    send_token(32'h1234);
    model_ready = 1'b1;
    word_idx    = 0;
    for (int r = 0; r < 3; r++) run_row(rows[r]);

    // Abandon a fill after 50 words; a token already waiting must not be taken
    // in the first cycle after reset.
    send_token(32'd1);
    model_ready = 1'b1;
    word_idx    = 0;
    for (int i = 0; i < 50; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'd7;
      cycle(d);
    end
    RST            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.comm_q     = 32'd3;
    bus.comm_empty = 1'b0;
    cycle(d);
    RST         = 1'b0;
    model_ready = 1'b0;
    word_idx    = 0;
    exp_we      = 1'b0;
    last_tok    = '0;
    check_zero();
    send_token(32'd3);
    model_ready = 1'b1;
    word_idx    = 0;
    run_row(rst_row);

    chk("writes_pending", wq.size(), 0);
    chk("tokens_pending", tq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
